audio_event_sequencer: RTL and testbench

- Driver side of the game-to-audio request interface: converts one-cycle game event pulses into held, mutually exclusive sound-request levels (jumpForward/jumpBackward/jumpRight/jumpLeft/win/lose) that the audio mux consumes.
- Holds each request for a fixed duration so the tone plays long enough to hear.
- Arbitrates retriggers and preemption.
- Sits between the game FSM and the audio mux/tone generators.

---
 rtl/audio_pkg.sv | 37 +++
 rtl/duration_timer.sv | 25 ++
 rtl/audio_event_sequencer.sv | 122 ++++++++++++
 tb/tb_audio_event_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and default hold times for the game-to-audio request path.
// The tone generators import the same cycle-count constants.
package audio_pkg;

  typedef enum logic [1:0] {IDLE, JUMP, WIN, LOSE} state_t;
  typedef enum logic [1:0] {FWD, BWD, RGT, LFT} dir_t;

  localparam int JUMP_CYCLES_DEF = 4_800_000;
  localparam int WIN_CYCLES_DEF  = 48_000_000;
  localparam int LOSE_CYCLES_DEF = 48_000_000;
  localparam int CNT_W_DEF       = 26;

  typedef struct packed {
    logic busy;
    logic lose;
    logic win;
    logic jumpLeft;
    logic jumpRight;
    logic jumpBackward;
    logic jumpForward;
  } req_t;

  // One-hot request decode; busy follows any active request.
  function automatic req_t reqOf(input state_t st, input dir_t d);
    req_t r;
    r = '0;
    r.jumpForward  = (st == JUMP) && (d == FWD);
    r.jumpBackward = (st == JUMP) && (d == BWD);
    r.jumpRight    = (st == JUMP) && (d == RGT);
    r.jumpLeft     = (st == JUMP) && (d == LFT);
    r.win          = (st == WIN);
    r.lose         = (st == LOSE);
    r.busy         = (st != IDLE);
    return r;
  endfunction

endpackage

// File: rtl/duration_timer.sv
// Loadable down-counter that parks at zero; done flags the terminal count.
module duration_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/audio_event_sequencer.sv
// Turns one-cycle game event pulses into held, mutually exclusive sound requests.
// state | meaning
// IDLE  | no request held
// JUMP  | jump sound held, direction in dir
// WIN   | win sound held, only lose preempts
// LOSE  | lose sound held, only lose restarts
module audio_event_sequencer
  import audio_pkg::*;
#(
  parameter int JUMP_CYCLES = JUMP_CYCLES_DEF,
  parameter int WIN_CYCLES  = WIN_CYCLES_DEF,
  parameter int LOSE_CYCLES = LOSE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic move_up_p,
  input  logic move_down_p,
  input  logic move_right_p,
  input  logic move_left_p,
  input  logic win_p,
  input  logic lose_p,
  output logic jumpForward,
  output logic jumpBackward,
  output logic jumpRight,
  output logic jumpLeft,
  output logic win,
  output logic lose,
  output logic busy
);

  localparam logic [CNT_W-1:0] JUMP_LOAD = CNT_W'(JUMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LOAD  = CNT_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSE_LOAD = CNT_W'(LOSE_CYCLES - 1);

  state_t           state, nextState;
  dir_t             dir, nextDir, jumpDir;
  req_t             req, nextReq;
  logic             timerLoad, timerDone, jumpAny;
  logic [CNT_W-1:0] timerLoadVal;

  duration_timer #(.CNT_W(CNT_W)) uTimer (
    .clk      (clk),
    .reset    (reset),
    .load     (timerLoad),
    .load_val (timerLoadVal),
    .done     (timerDone)
  );

  assign jumpAny = move_up_p | move_down_p | move_right_p | move_left_p;

  always_comb begin
    jumpDir = LFT;
    if (move_up_p)         jumpDir = FWD;
    else if (move_down_p)  jumpDir = BWD;
    else if (move_right_p) jumpDir = RGT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dir   <= FWD;
      req   <= '0;
    end else begin
      state <= nextState;
      dir   <= nextDir;
      req   <= nextReq;
    end
  end

  // An event on the expiry cycle is judged against the still-active state.
  always_comb begin
    nextState    = state;
    nextDir      = dir;
    timerLoad    = 1'b0;
    timerLoadVal = '0;
    case (state)
      IDLE, JUMP: begin
        if (lose_p) begin
          nextState = LOSE;  timerLoad = 1'b1;  timerLoadVal = LOSE_LOAD;
        end else if (win_p) begin
          nextState = WIN;   timerLoad = 1'b1;  timerLoadVal = WIN_LOAD;
        end else if (jumpAny) begin
          nextState = JUMP;  nextDir = jumpDir;
          timerLoad = 1'b1;  timerLoadVal = JUMP_LOAD;
        end else if (state == JUMP && timerDone) begin
          nextState = IDLE;
        end
      end
      WIN: begin
        if (lose_p) begin
          nextState = LOSE;  timerLoad = 1'b1;  timerLoadVal = LOSE_LOAD;
        end else if (win_p) begin
          timerLoad = 1'b1;  timerLoadVal = WIN_LOAD;
        end else if (timerDone) begin
          nextState = IDLE;
        end
      end
      LOSE: begin
        if (lose_p) begin
          timerLoad = 1'b1;  timerLoadVal = LOSE_LOAD;
        end else if (timerDone) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    nextReq = reqOf(nextState, nextDir);
  end

  assign jumpForward  = req.jumpForward;
  assign jumpBackward = req.jumpBackward;
  assign jumpRight    = req.jumpRight;
  assign jumpLeft     = req.jumpLeft;
  assign win          = req.win;
  assign lose         = req.lose;
  assign busy         = req.busy;

endmodule

// File: tb/tb_audio_event_sequencer.sv
// Directed bench for audio_event_sequencer with short hold times (4/8/6 cycles).
module tb_audio_event_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic move_up_p = 0, move_down_p = 0, move_right_p = 0, move_left_p = 0;
  logic win_p = 0, lose_p = 0;
  logic jumpForward, jumpBackward, jumpRight, jumpLeft, win, lose, busy;

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] sb[$];

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] UP   = 6'b000001;
  localparam logic [5:0] DOWN = 6'b000010;
  localparam logic [5:0] RGT  = 6'b000100;
  localparam logic [5:0] LFT  = 6'b001000;
  localparam logic [5:0] WINP = 6'b010000;
  localparam logic [5:0] LOSP = 6'b100000;

  audio_event_sequencer #(
    .JUMP_CYCLES(4), .WIN_CYCLES(8), .LOSE_CYCLES(6), .CNT_W(26)
  ) dut (
    .clk(clk), .reset(reset),
    .move_up_p(move_up_p), .move_down_p(move_down_p),
    .move_right_p(move_right_p), .move_left_p(move_left_p),
    .win_p(win_p), .lose_p(lose_p),
    .jumpForward(jumpForward), .jumpBackward(jumpBackward),
    .jumpRight(jumpRight), .jumpLeft(jumpLeft),
    .win(win), .lose(lose), .busy(busy)
  );

  always #5 clk = ~clk;

  wire [6:0] outVec = {busy, lose, win, jumpLeft, jumpRight, jumpBackward, jumpForward};

  function automatic bit inR(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Expected vector; busy is the OR of the six requests.
  function automatic logic [6:0] ev(input bit f, input bit b, input bit r,
                                    input bit l, input bit w, input bit s);
    return {f | b | r | l | w | s, s, w, l, r, b, f};
  endfunction

  // Pulses for cycle c are sampled at the next edge; outputs are checked as cycle c+1.
  task automatic step(input string tag, input int c, input logic [5:0] p, input logic [6:0] e);
    logic [6:0] obs, expv;
    {lose_p, win_p, move_left_p, move_right_p, move_down_p, move_up_p} = p;
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs  = outVec;
    expv = sb.pop_front();
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s cycle %0d observed %b expected %b", tag, c + 1, obs, expv);
    end
  endtask

  task automatic restart();
    {lose_p, win_p, move_left_p, move_right_p, move_down_p, move_up_p} = NONE;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] obs;
    restart();

    // Reset state
    for (int c = 0; c < 3; c++) step("reset_idle", c, NONE, ev(0,0,0,0,0,0));

    // Asynchronous reset in the middle of WIN
    restart();
    for (int c = 0; c < 4; c++)
      step("pre_reset_win", c, (c == 0) ? WINP : NONE, ev(0,0,0,0,inR(c+1,1,8),0));
    #2 reset = 1'b1;
    #1 obs = outVec;
    vectors++;
    assert (obs === 7'b0) else begin
      miscompares++;
      $error("FAIL async_reset observed %b expected %b", obs, 7'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) step("post_reset_idle", c, NONE, ev(0,0,0,0,0,0));
    for (int c = 0; c < 6; c++)
      step("post_reset_up", c, (c == 0) ? UP : NONE, ev(inR(c+1,1,4),0,0,0,0,0));

    // Single forward jump
    restart();
    for (int c = 0; c < 18; c++)
      step("up_single", c, (c == 10) ? UP : NONE, ev(inR(c+1,11,14),0,0,0,0,0));

    // Jump retrigger with direction change
    restart();
    for (int c = 0; c < 19; c++)
      step("up_then_left", c, (c == 10) ? UP : (c == 12) ? LFT : NONE,
           ev(inR(c+1,11,12),0,0,inR(c+1,13,16),0,0));

    // Simultaneous pulses: win beats jumps; jumps ignored during WIN
    restart();
    for (int c = 0; c < 16; c++)
      step("win_priority", c, (c == 5) ? (RGT | DOWN | WINP) : (c == 8) ? UP : NONE,
           ev(0,0,0,0,inR(c+1,6,13),0));

    // Lose preempts win; win ignored during LOSE
    restart();
    for (int c = 0; c < 12; c++)
      step("lose_preempt", c, (c == 0) ? WINP : (c == 3) ? LOSP : (c == 5) ? WINP : NONE,
           ev(0,0,0,0,inR(c+1,1,3),inR(c+1,4,9)));

    // Retrigger on the expiry cycle: no idle gap
    restart();
    for (int c = 0; c < 15; c++)
      step("expiry_retrigger", c, (c == 4) ? LFT : (c == 8) ? UP : NONE,
           ev(inR(c+1,9,12),0,0,inR(c+1,5,8),0,0));

    // Held input retriggers every cycle
    restart();
    for (int c = 0; c < 10; c++)
      step("held_down", c, (c < 4) ? DOWN : NONE, ev(0,inR(c+1,1,7),0,0,0,0));

    // Lose beats win; lose restarts itself; jumps ignored during LOSE
    restart();
    for (int c = 0; c < 11; c++)
      step("lose_restart", c, (c == 0) ? (LOSP | WINP) : (c == 2) ? LOSP : (c == 4) ? RGT : NONE,
           ev(0,0,0,0,0,inR(c+1,1,8)));

    // Jump priority among simultaneous directions
    restart();
    for (int c = 0; c < 6; c++)
      step("right_over_left", c, (c == 0) ? (RGT | LFT) : NONE, ev(0,0,inR(c+1,1,4),0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
